move_arbiter: RTL and testbench
===============================

Name: move_arbiter

Overview:
- Sits between two move sources (player 1 and player 2 keypads or agents) and the game controller's playerWrite/playerInput interface.
- Enforces turn order.
- Rejects illegal moves by reading the current gBoard.
- Forces a default move when a player exceeds the turn timer.
- Confirms each move has landed in the board memory before passing the turn.

Parameters:
TURN_TIMEOUT, 1000, cycles in TURN without a legal move before an automatic move is issued (must be >= 2)
WAIT_LIMIT, 8, max cycles in WAIT for the written cell to become non-empty before flagging an error
TIMER_W, $clog2(TURN_TIMEOUT+1), turn timer width (derived, not overridden)

Ports:
ph1  input  1  sole clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
newGame  input  1  start request, honoured only in IDLE or DONE
isPlayer1Start  input  1  sampled when newGame is accepted; 1 = player 1 moves first
gameIsDone  input  1  from win logic
gBoard  input  18  cell i at bits [2i+1:2i]; 00 empty, 11 player 1, 10 player 2
p1Req  input  1  player 1 move request, level
p1Cell  input  4  player 1 requested cell 0..8
p1Ack  output  1  one-cycle pulse: p1 move accepted
p1Nack  output  1  one-cycle pulse: p1 move rejected
p2Req, p2Cell, p2Ack, p2Nack  as for p1
playerWrite  output  1  one-cycle write strobe to game controller
playerInput  output  4  cell index, valid while playerWrite=1
turnIsP1  output  1  1 while player 1 holds the turn
timeoutMove  output  1  one-cycle pulse with playerWrite when the move was auto-generated
err  output  1  sticky; set on WAIT_LIMIT expiry, cleared by accepted newGame
arbState  output  3  current state encoding, for debug

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. Timers 0. Latched cell 0.
- All outputs are registered or decoded from state registers. No combinational input->output path.
- States: IDLE=0, TURN=1, ISSUE=2, WAIT=3, DONE=4.
- IDLE/DONE, newGame=1:
  - go to TURN
  - turnIsP1 <= isPlayer1Start
  - turn timer <= 0, err <= 0
- TURN, evaluated in priority order each cycle:
  1. gameIsDone=1 -> DONE.
  2. Current player's Req=1: legal means Cell<=8 and gBoard cell==00.
     - Legal: latch cell, go ISSUE, assert that player's Ack next cycle.
     - Illegal: assert that player's Nack next cycle, stay in TURN. Timer continues.
  3. Else, timer==TURN_TIMEOUT-1: latch lowest-index empty cell, go ISSUE with timeoutMove=1.
     - If no empty cell exists, go DONE.
  4. Else timer++.
- Off-turn Req=1 in TURN: that player's Nack pulses next cycle, every cycle the Req is held. No effect on state.
- Req in any state other than TURN: ignored, no Ack/Nack.
- A legal request on the same cycle the timer expires wins; timeoutMove=0.
- ISSUE (exactly one cycle):
  - playerWrite=1, playerInput=latched cell.
  - Ack (or timeoutMove) is high in this same cycle.
  - Next state WAIT; wait counter <= 0.
- WAIT:
  - gBoard latched cell != 00: go DONE if gameIsDone=1, else toggle turnIsP1, timer <= 0, go TURN.
  - Else wait counter++. At WAIT_LIMIT-1: err <= 1, go DONE.
- DONE: holds until newGame. turnIsP1 holds its last value.
- newGame in TURN/ISSUE/WAIT is ignored; it does not abort a move in flight.
- Reset asserted mid-move: immediate return to IDLE. A playerWrite already high drops with reset.
- Latency: legal Req sampled at edge N -> playerWrite high in cycle N+1 -> earliest next TURN at N+3 (board updates one cycle after write).

Decomposition:
- Shared package tictactoe_pkg:
  - cell codes CELL_EMPTY/CELL_P1/CELL_P2
  - winner codes (11 p1, 10 p2, 01 tie, 00 none)
  - NUM_CELLS=9
  - arb_state_t enum
  - cell index type (4 bits)
- Sub-module first_empty_cell: combinational priority encoder, gBoard -> {found, index of lowest 00 cell}. Used for the timeout move.

Test Plan:
- Reset with all inputs toggling -> all outputs 0, arbState=0. Release, newGame=1 with isPlayer1Start=1 -> arbState=1, turnIsP1=1.
- P1 turn, p1Req=1 p1Cell=4 on empty board -> next cycle p1Ack=1, playerWrite=1, playerInput=4. Bench board sets cell 4 to 11 one cycle later -> turnIsP1=0, state TURN.
- P2 turn, cell 4 occupied, p2Req with p2Cell=4 -> p2Nack pulse, no playerWrite. Then p2Cell=9 -> p2Nack. Concurrent p1Req=1 -> p1Nack each held cycle.
- TURN_TIMEOUT=5, cells 0,1 occupied, no requests -> after 5 cycles in TURN: playerWrite=1, playerInput=2, timeoutMove=1. Then with p1Req legal on the expiry cycle -> p1Ack=1, timeoutMove=0.
- Bench never updates gBoard after write -> err=1 and state DONE after WAIT_LIMIT=8 WAIT cycles. newGame -> err=0, TURN.
- gameIsDone=1 with the written cell visible in WAIT -> DONE, no turn toggle. Assert reset during ISSUE -> playerWrite drops immediately, state IDLE.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared tic-tac-toe definitions: cell codes, winner codes, arbiter states
// and a bounds-safe board cell lookup.
package tictactoe_pkg;

    localparam int NUM_CELLS = 9;

    typedef logic [3:0] cell_idx_t;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_P1    = 2'b11;
    localparam logic [1:0] CELL_P2    = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_TIE  = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_P1   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } arb_state_t;

    // Out-of-range indices read as occupied so they can never be played.
    function automatic logic [1:0] cell_at(input logic [2*NUM_CELLS-1:0] board,
                                           input cell_idx_t idx);
        logic [1:0] code;
        if (idx < cell_idx_t'(NUM_CELLS)) begin
            code = board[2*idx +: 2];
        end else begin
            code = CELL_P1;
        end
        return code;
    endfunction

endpackage

// File: rtl/first_empty_cell.sv
// Combinational priority encoder: index of the lowest empty board cell.
module first_empty_cell
    import tictactoe_pkg::*;
(
    input  logic [2*NUM_CELLS-1:0] board,
    output logic                   found,
    output cell_idx_t              index
);

    // Scan from the highest cell down so the lowest empty cell is the last writer.
    always_comb begin
        found = 1'b0;
        index = 4'd0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (board[2*i +: 2] == CELL_EMPTY) begin
                found = 1'b1;
                index = cell_idx_t'(i);
            end else begin
                found = found;
                index = index;
            end
        end
    end

endmodule

// File: rtl/move_arbiter.sv
// Turn-order arbiter between two move sources and the game controller.
// Checks legality against the board, issues timeout moves, and waits for
// each written cell to appear in the board before handing over the turn.
module move_arbiter
    import tictactoe_pkg::*;
#(
    parameter int TURN_TIMEOUT = 1000,
    parameter int WAIT_LIMIT   = 8
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        newGame,
    input  logic        isPlayer1Start,
    input  logic        gameIsDone,
    input  logic [17:0] gBoard,
    input  logic        p1Req,
    input  logic [3:0]  p1Cell,
    output logic        p1Ack,
    output logic        p1Nack,
    input  logic        p2Req,
    input  logic [3:0]  p2Cell,
    output logic        p2Ack,
    output logic        p2Nack,
    output logic        playerWrite,
    output logic [3:0]  playerInput,
    output logic        turnIsP1,
    output logic        timeoutMove,
    output logic        err,
    output logic [2:0]  arbState
);

    localparam int TIMER_W = $clog2(TURN_TIMEOUT + 1);
    localparam int WAIT_W  = $clog2(WAIT_LIMIT + 1);

    arb_state_t         state_r;
    logic [TIMER_W-1:0] timer_r;
    logic [WAIT_W-1:0]  wait_r;
    cell_idx_t          cell_r;

    logic      cur_req_s;
    cell_idx_t cur_cell_s;
    logic      off_req_s;
    logic      cur_legal_s;
    logic      landed_s;
    logic      fe_found_s;
    cell_idx_t fe_index_s;

    first_empty_cell u_first_empty (
        .board (gBoard),
        .found (fe_found_s),
        .index (fe_index_s)
    );

    // Route the requests of the player holding the turn and judge legality.
    always_comb begin
        cur_req_s   = turnIsP1 ? p1Req  : p2Req;
        cur_cell_s  = turnIsP1 ? p1Cell : p2Cell;
        off_req_s   = turnIsP1 ? p2Req  : p1Req;
        cur_legal_s = (cur_cell_s <= cell_idx_t'(NUM_CELLS - 1)) &&
                      (cell_at(gBoard, cur_cell_s) == CELL_EMPTY);
        landed_s    = (cell_at(gBoard, cell_r) != CELL_EMPTY);
    end

    assign playerInput = cell_r;
    assign arbState    = state_r;

    // Arbiter FSM with all handshake outputs registered.
    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            wait_r      <= '0;
            cell_r      <= 4'd0;
            p1Ack       <= 1'b0;
            p1Nack      <= 1'b0;
            p2Ack       <= 1'b0;
            p2Nack      <= 1'b0;
            playerWrite <= 1'b0;
            timeoutMove <= 1'b0;
            turnIsP1    <= 1'b0;
            err         <= 1'b0;
        end else begin
            p1Ack       <= 1'b0;
            p1Nack      <= 1'b0;
            p2Ack       <= 1'b0;
            p2Nack      <= 1'b0;
            playerWrite <= 1'b0;
            timeoutMove <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (newGame) begin
                        state_r  <= ST_TURN;
                        turnIsP1 <= isPlayer1Start;
                        timer_r  <= '0;
                        err      <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_TURN: begin
                    // The waiting player is refused on every cycle it asks.
                    if (off_req_s) begin
                        if (turnIsP1) begin
                            p2Nack <= 1'b1;
                        end else begin
                            p1Nack <= 1'b1;
                        end
                    end else begin
                        p1Nack <= 1'b0;
                    end
                    if (gameIsDone) begin
                        state_r <= ST_DONE;
                    end else if (cur_req_s) begin
                        if (cur_legal_s) begin
                            cell_r      <= cur_cell_s;
                            state_r     <= ST_ISSUE;
                            playerWrite <= 1'b1;
                            if (turnIsP1) begin
                                p1Ack <= 1'b1;
                            end else begin
                                p2Ack <= 1'b1;
                            end
                        end else begin
                            if (turnIsP1) begin
                                p1Nack <= 1'b1;
                            end else begin
                                p2Nack <= 1'b1;
                            end
                            // Saturate so expiry fires on the next request-free cycle.
                            if (timer_r < TIMER_W'(TURN_TIMEOUT - 1)) begin
                                timer_r <= timer_r + TIMER_W'(1);
                            end else begin
                                timer_r <= timer_r;
                            end
                        end
                    end else if (timer_r >= TIMER_W'(TURN_TIMEOUT - 1)) begin
                        if (fe_found_s) begin
                            cell_r      <= fe_index_s;
                            state_r     <= ST_ISSUE;
                            playerWrite <= 1'b1;
                            timeoutMove <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT;
                    wait_r  <= '0;
                end
                ST_WAIT: begin
                    if (landed_s) begin
                        if (gameIsDone) begin
                            state_r <= ST_DONE;
                        end else begin
                            turnIsP1 <= ~turnIsP1;
                            timer_r  <= '0;
                            state_r  <= ST_TURN;
                        end
                    end else if (wait_r == WAIT_W'(WAIT_LIMIT - 1)) begin
                        err     <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        wait_r <= wait_r + WAIT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_arbiter.sv
// Scoreboard bench for move_arbiter: stimulus pushes expected handshake
// events, a monitor pops and compares them whenever the DUT strobes.
module tb_move_arbiter;

    logic        ph1 = 1'b0;
    logic        reset;
    logic        newGame;
    logic        isPlayer1Start;
    logic        gameIsDone;
    logic [17:0] gBoard;
    logic        p1Req;
    logic [3:0]  p1Cell;
    logic        p1Ack;
    logic        p1Nack;
    logic        p2Req;
    logic [3:0]  p2Cell;
    logic        p2Ack;
    logic        p2Nack;
    logic        playerWrite;
    logic [3:0]  playerInput;
    logic        turnIsP1;
    logic        timeoutMove;
    logic        err;
    logic [2:0]  arbState;

    int checks = 0;
    int errors = 0;
    logic [9:0] exp_q[$];
    logic board_auto = 1'b0;

    move_arbiter #(.TURN_TIMEOUT(5), .WAIT_LIMIT(8)) dut (
        .ph1(ph1), .reset(reset), .newGame(newGame), .isPlayer1Start(isPlayer1Start),
        .gameIsDone(gameIsDone), .gBoard(gBoard),
        .p1Req(p1Req), .p1Cell(p1Cell), .p1Ack(p1Ack), .p1Nack(p1Nack),
        .p2Req(p2Req), .p2Cell(p2Cell), .p2Ack(p2Ack), .p2Nack(p2Nack),
        .playerWrite(playerWrite), .playerInput(playerInput), .turnIsP1(turnIsP1),
        .timeoutMove(timeoutMove), .err(err), .arbState(arbState)
    );

    always #5 ph1 = ~ph1;

    // Event record: {write, cell (only while writing), timeout, a1, n1, a2, n2}
    function automatic logic [9:0] ev(input logic pw, input logic [3:0] pin, input logic tm,
                                      input logic a1, input logic n1, input logic a2, input logic n2);
        return {pw, pin, tm, a1, n1, a2, n2};
    endfunction

    task automatic tick();
        @(posedge ph1);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every strobe against the scoreboard; model the board write.
    initial begin
        logic [9:0] act;
        logic [9:0] e;
        logic [1:0] code;
        int         idx;
        forever begin
            @(negedge ph1);
            if (reset && (playerWrite || p1Ack || p1Nack || p2Ack || p2Nack)) begin
                act = {playerWrite, (playerWrite ? playerInput : 4'd0), timeoutMove,
                       p1Ack, p1Nack, p2Ack, p2Nack};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: got %b expected none at %0t", act, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL event: got %b expected %b at %0t", act, e, $time);
                    end
                end
                if (playerWrite && board_auto) begin
                    code = turnIsP1 ? 2'b11 : 2'b10;
                    idx  = int'(playerInput);
                    @(posedge ph1);
                    #1;
                    if (idx < 9) gBoard[idx*2 +: 2] = code;
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        newGame = 1'b0; isPlayer1Start = 1'b0; gameIsDone = 1'b0; gBoard = 18'd0;
        p1Req = 1'b0; p1Cell = 4'd0; p2Req = 1'b0; p2Cell = 4'd0;

        // Reset held while inputs toggle: outputs stay zero.
        for (int i = 0; i < 4; i++) begin
            newGame = 1'($urandom); isPlayer1Start = 1'($urandom); gameIsDone = 1'($urandom);
            gBoard = 18'($urandom); p1Req = 1'($urandom); p1Cell = 4'($urandom);
            p2Req = 1'($urandom); p2Cell = 4'($urandom);
            tick();
            chk("reset_outputs", {p1Ack, p1Nack, p2Ack, p2Nack, playerWrite, playerInput,
                                  turnIsP1, timeoutMove, err, arbState}, 32'd0);
        end
        newGame = 1'b0; isPlayer1Start = 1'b0; gameIsDone = 1'b0; gBoard = 18'd0;
        p1Req = 1'b0; p1Cell = 4'd0; p2Req = 1'b0; p2Cell = 4'd0;
        reset = 1'b1;
        tick();

        // New game, player 1 starts.
        newGame = 1'b1; isPlayer1Start = 1'b1;
        tick();
        newGame = 1'b0;
        chk("newgame_state", arbState, 32'd1);
        chk("newgame_p1", turnIsP1, 32'd1);

        // Player 1 plays cell 4 on an empty board.
        board_auto = 1'b1;
        p1Req = 1'b1; p1Cell = 4'd4;
        exp_q.push_back(ev(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        tick();
        p1Req = 1'b0;
        chk("issue_state", arbState, 32'd2);
        tick();
        chk("wait_state", arbState, 32'd3);
        tick();
        chk("turn_after_p1", arbState, 32'd1);
        chk("turn_to_p2", turnIsP1, 32'd0);

        // Player 2 asks for occupied cell 4.
        p2Req = 1'b1; p2Cell = 4'd4;
        exp_q.push_back(ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        tick();
        chk("nack_occupied_state", arbState, 32'd1);
        // Out-of-range cell, with player 1 requesting off-turn at the same time.
        p2Cell = 4'd9; p1Req = 1'b1; p1Cell = 4'd0;
        exp_q.push_back(ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        tick();
        chk("nack_range_state", arbState, 32'd1);
        p2Req = 1'b0;
        exp_q.push_back(ev(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        tick();
        chk("offturn_state", arbState, 32'd1);
        p1Req = 1'b0;
        tick();
        // Timer now sits at its expiry value: a legal request still wins.
        p2Req = 1'b1; p2Cell = 4'd0;
        exp_q.push_back(ev(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        p2Req = 1'b0;
        chk("expiry_legal_issue", arbState, 32'd2);
        tick();
        tick();
        chk("turn_back_p1", turnIsP1, 32'd1);

        // Timeout move: cells 0 and 1 taken, so cell 2 is chosen.
        gBoard[3:2] = 2'b11;
        for (int i = 0; i < 4; i++) tick();
        chk("timeout_not_yet", arbState, 32'd1);
        exp_q.push_back(ev(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        tick();
        chk("timeout_issue", arbState, 32'd2);
        tick();
        tick();
        chk("timeout_turn_p2", turnIsP1, 32'd0);

        // Board never updates: WAIT expires and raises err.
        board_auto = 1'b0;
        p2Req = 1'b1; p2Cell = 4'd8;
        exp_q.push_back(ev(1'b1, 4'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        p2Req = 1'b0;
        tick();
        for (int i = 0; i < 7; i++) tick();
        chk("wait_still", arbState, 32'd3);
        chk("err_not_yet", err, 32'd0);
        tick();
        chk("wait_expired_state", arbState, 32'd4);
        chk("err_set", err, 32'd1);
        // Requests are ignored in DONE.
        p1Req = 1'b1; p1Cell = 4'd3;
        tick();
        p1Req = 1'b0;
        chk("done_hold", arbState, 32'd4);
        chk("err_sticky", err, 32'd1);
        newGame = 1'b1; isPlayer1Start = 1'b0; gBoard = 18'd0;
        tick();
        newGame = 1'b0;
        chk("restart_state", arbState, 32'd1);
        chk("restart_err", err, 32'd0);
        chk("restart_p2", turnIsP1, 32'd0);

        // Game ends as the written cell lands: DONE, no turn change.
        board_auto = 1'b1;
        p2Req = 1'b1; p2Cell = 4'd3;
        exp_q.push_back(ev(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
        tick();
        p2Req = 1'b0; gameIsDone = 1'b1;
        tick();
        tick();
        chk("gamedone_state", arbState, 32'd4);
        chk("gamedone_no_toggle", turnIsP1, 32'd0);
        gameIsDone = 1'b0;

        // newGame held while in TURN is ignored.
        newGame = 1'b1; isPlayer1Start = 1'b1; gBoard = 18'd0;
        tick();
        isPlayer1Start = 1'b0;
        tick();
        newGame = 1'b0;
        chk("newgame_ignored_state", arbState, 32'd1);
        chk("newgame_ignored_turn", turnIsP1, 32'd1);

        // Reset during ISSUE drops the write strobe at once.
        board_auto = 1'b0;
        p1Req = 1'b1; p1Cell = 4'd5;
        tick();
        p1Req = 1'b0;
        chk("pre_reset_write", playerWrite, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_mid_outputs", {p1Ack, playerWrite, playerInput, timeoutMove, arbState}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("idle_after_reset", arbState, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
